// File: rtl/video_mem_pkg.sv
// Shared types and defaults for the video memory responder.
//   vm_state_t  : arbiter states (IDLE, VID_REQ, CPU_REQ)
//   VM_*        : default widths/limits used by the top and the fetch tracker
//   sat_inc4    : saturating 4-bit increment used for age and video streak
package video_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    VID_REQ = 2'd1,
    CPU_REQ = 2'd2
  } vm_state_t;

  localparam int VM_ADDR_W       = 17;
  localparam int VM_DEADLINE     = 3;
  localparam int VM_CPU_MAX_WAIT = 2;
  localparam int VM_AGE_W        = 4;
  localparam int VM_STREAK_W     = 4;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
    logic [3:0] r;
    if (v >= lim) begin
      r = lim;
    end else begin
      r = v + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/video_mem_responder_fetch_tracker.sv
// vidmem_fetch_tracker: owns the video-side cache tag and the outstanding
// fetch bookkeeping (tag_addr/tag_valid, req_addr, pending, age, underrun).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   pix_stb, vid_addr   : pixel strobe and requested video address
//   fill, fill_addr     : a byte for fill_addr is now held in vid_din
//                         (video completion or CPU write snoop)
//   pending, req_addr   : outstanding fetch request towards the arbiter
//   tag_addr, tag_valid : address whose byte vid_din currently holds
//   age                 : only with VIDMEM_STATS_EN, pix_stb periods waited
//   underrun            : sticky deadline miss
module vidmem_fetch_tracker
  import video_mem_pkg::*;
#(
  parameter int ADDR_W   = VM_ADDR_W,
  parameter int DEADLINE = VM_DEADLINE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pix_stb,
  input  logic [ADDR_W-1:0]   vid_addr,
  input  logic                fill,
  input  logic [ADDR_W-1:0]   fill_addr,
  output logic                pending,
  output logic [ADDR_W-1:0]   req_addr,
  output logic [ADDR_W-1:0]   tag_addr,
  output logic                tag_valid,
`ifdef VIDMEM_STATS_EN
  output logic [VM_AGE_W-1:0] age,
`endif
  output logic                underrun
);

  localparam int AGE_MAX_INT = DEADLINE + 1;
  localparam logic [VM_AGE_W-1:0] AGE_MAX = AGE_MAX_INT[VM_AGE_W-1:0];

  logic [ADDR_W-1:0]   tag_addr_q, tag_addr_d;
  logic                tag_valid_q, tag_valid_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic                pending_q, pending_d;
  logic [VM_AGE_W-1:0] age_q, age_d;
  logic                underrun_q, underrun_d;
  logic [ADDR_W-1:0]   cmp_addr;

  // Next-state logic for the tag, the outstanding request, its age and underrun.
  always_comb begin
    tag_addr_d  = tag_addr_q;
    tag_valid_d = tag_valid_q;
    req_addr_d  = req_addr_q;
    pending_d   = pending_q;
    age_d       = age_q;
    // While a fetch is outstanding, compare against what is being fetched so
    // that a held address does not re-arm the request every strobe.
    cmp_addr    = pending_q ? req_addr_q : tag_addr_q;

    if (fill) begin
      tag_addr_d  = fill_addr;
      tag_valid_d = 1'b1;
      if (pending_q && (fill_addr == req_addr_q)) begin
        pending_d = 1'b0;
      end else begin
        pending_d = pending_q;
      end
    end else begin
      tag_valid_d = tag_valid_q;
    end

    // A new address on the strobe wins over a same-cycle completion.
    if (pix_stb) begin
      if ((!pending_q && !tag_valid_q) || (vid_addr != cmp_addr)) begin
        pending_d  = 1'b1;
        req_addr_d = vid_addr;
        age_d      = {VM_AGE_W{1'b0}};
      end else if (pending_d) begin
        age_d = sat_inc4(age_q, AGE_MAX);
      end else begin
        age_d = age_q;
      end
    end else begin
      age_d = age_q;
    end

    underrun_d = underrun_q | (age_d == AGE_MAX);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_addr_q  <= {ADDR_W{1'b0}};
      tag_valid_q <= 1'b0;
      req_addr_q  <= {ADDR_W{1'b0}};
      pending_q   <= 1'b0;
      age_q       <= {VM_AGE_W{1'b0}};
      underrun_q  <= 1'b0;
    end else begin
      tag_addr_q  <= tag_addr_d;
      tag_valid_q <= tag_valid_d;
      req_addr_q  <= req_addr_d;
      pending_q   <= pending_d;
      age_q       <= age_d;
      underrun_q  <= underrun_d;
    end
  end

  assign pending   = pending_q;
  assign req_addr  = req_addr_q;
  assign tag_addr  = tag_addr_q;
  assign tag_valid = tag_valid_q;
  assign underrun  = underrun_q;
`ifdef VIDMEM_STATS_EN
  assign age       = age_q;
`endif

endmodule

// File: rtl/video_mem_responder.sv
// video_mem_responder: serves the video controller's byte read port from a
// shared RAM request/ack port, arbitrating with CPU accesses (video first,
// CPU guaranteed a slot after CPU_MAX_WAIT consecutive video fetches).
// Ports:
//   clk_sys, reset             : clock, asynchronous active-high reset
//   pix_stb, vid_addr, vid_din : video read port (vid_din holds between fetches)
//   mem_req/we/addr/wdata      : RAM request, held until mem_ack
//   mem_ack, mem_rdata         : RAM completion pulse and read data
//   cpu_req/we/addr/wdata      : CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack         : CPU read data and completion pulse
//   underrun                   : sticky video deadline miss
// Optional build macro VIDMEM_STATS_EN adds vsync input and fetch_count,
// cpu_count, max_age statistics outputs.
module video_mem_responder
  import video_mem_pkg::*;
#(
  parameter int ADDR_W       = VM_ADDR_W,
  parameter int DEADLINE     = VM_DEADLINE,
  parameter int CPU_MAX_WAIT = VM_CPU_MAX_WAIT
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              pix_stb,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_din,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
`ifdef VIDMEM_STATS_EN
  input  logic              vsync,
  output logic [15:0]       fetch_count,
  output logic [15:0]       cpu_count,
  output logic [3:0]        max_age,
`endif
  output logic              underrun
);

  localparam logic [VM_STREAK_W-1:0] STREAK_LIM = CPU_MAX_WAIT[VM_STREAK_W-1:0];

  vm_state_t               state_q, state_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [7:0]              mem_wdata_q, mem_wdata_d;
  logic [7:0]              vid_din_q, vid_din_d;
  logic [7:0]              cpu_rdata_q, cpu_rdata_d;
  logic                    cpu_ack_q, cpu_ack_d;
  logic [VM_STREAK_W-1:0]  vid_streak_q, vid_streak_d;

  logic                    pending_s;
  logic [ADDR_W-1:0]       req_addr_s;
  logic [ADDR_W-1:0]       tag_addr_s;
  logic                    tag_valid_s;
  logic                    fill_s;
  logic [ADDR_W-1:0]       fill_addr_s;
`ifdef VIDMEM_STATS_EN
  logic [VM_AGE_W-1:0]     age_s;
`endif

  vidmem_fetch_tracker #(
    .ADDR_W   (ADDR_W),
    .DEADLINE (DEADLINE)
  ) u_tracker (
    .clk       (clk_sys),
    .rst       (reset),
    .pix_stb   (pix_stb),
    .vid_addr  (vid_addr),
    .fill      (fill_s),
    .fill_addr (fill_addr_s),
    .pending   (pending_s),
    .req_addr  (req_addr_s),
    .tag_addr  (tag_addr_s),
    .tag_valid (tag_valid_s),
`ifdef VIDMEM_STATS_EN
    .age       (age_s),
`endif
    .underrun  (underrun)
  );

  // Arbiter FSM next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    vid_din_d    = vid_din_q;
    cpu_rdata_d  = cpu_rdata_q;
    cpu_ack_d    = 1'b0;
    vid_streak_d = vid_streak_q;
    fill_s       = 1'b0;
    fill_addr_s  = mem_addr_q;

    case (state_q)
      IDLE: begin
        if (pending_s && (!cpu_req || (vid_streak_q < STREAK_LIM))) begin
          state_d    = VID_REQ;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = req_addr_s;
        // cpu_req is still high during the cpu_ack cycle; do not re-serve it.
        end else if (cpu_req && !cpu_ack_q) begin
          state_d     = CPU_REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = cpu_we;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
        end else begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      VID_REQ: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          // A result for an address the controller has since moved away from
          // is dropped; the tracker keeps the new request pending.
          if (mem_addr_q == req_addr_s) begin
            vid_din_d    = mem_rdata;
            fill_s       = 1'b1;
            vid_streak_d = sat_inc4(vid_streak_q, STREAK_LIM);
          end else begin
            vid_din_d = vid_din_q;
          end
        end else begin
          state_d = VID_REQ;
        end
      end
      CPU_REQ: begin
        if (mem_ack) begin
          state_d      = IDLE;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          cpu_ack_d    = 1'b1;
          vid_streak_d = {VM_STREAK_W{1'b0}};
          if (!mem_we_q) begin
            cpu_rdata_d = mem_rdata;
          // Snoop: a write to the displayed byte refreshes it without refetch.
          end else if (tag_valid_s && (mem_addr_q == tag_addr_s)) begin
            vid_din_d = mem_wdata_q;
            fill_s    = 1'b1;
          end else begin
            cpu_rdata_d = cpu_rdata_q;
          end
        end else begin
          state_d = CPU_REQ;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // FSM state and output registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= 8'h00;
      vid_din_q    <= 8'h00;
      cpu_rdata_q  <= 8'h00;
      cpu_ack_q    <= 1'b0;
      vid_streak_q <= {VM_STREAK_W{1'b0}};
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      vid_din_q    <= vid_din_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      vid_streak_q <= vid_streak_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign vid_din   = vid_din_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;

`ifdef VIDMEM_STATS_EN
  logic                vsync_q;
  logic [15:0]         fetch_count_q, fetch_count_d;
  logic [15:0]         cpu_count_q, cpu_count_d;
  logic [VM_AGE_W-1:0] max_age_q, max_age_d;
  logic                vid_done_s, cpu_done_s;

  // Statistics counters; cleared on a vsync rising edge.
  always_comb begin
    vid_done_s    = (state_q == VID_REQ) && mem_ack && (mem_addr_q == req_addr_s);
    cpu_done_s    = (state_q == CPU_REQ) && mem_ack;
    fetch_count_d = fetch_count_q;
    cpu_count_d   = cpu_count_q;
    max_age_d     = max_age_q;
    if (vsync && !vsync_q) begin
      fetch_count_d = 16'd0;
      cpu_count_d   = 16'd0;
      max_age_d     = {VM_AGE_W{1'b0}};
    end else begin
      if (vid_done_s) begin
        fetch_count_d = fetch_count_q + 16'd1;
        max_age_d     = (age_s > max_age_q) ? age_s : max_age_q;
      end else begin
        fetch_count_d = fetch_count_q;
      end
      if (cpu_done_s) begin
        cpu_count_d = cpu_count_q + 16'd1;
      end else begin
        cpu_count_d = cpu_count_q;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      vsync_q       <= 1'b0;
      fetch_count_q <= 16'd0;
      cpu_count_q   <= 16'd0;
      max_age_q     <= {VM_AGE_W{1'b0}};
    end else begin
      vsync_q       <= vsync;
      fetch_count_q <= fetch_count_d;
      cpu_count_q   <= cpu_count_d;
      max_age_q     <= max_age_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign cpu_count   = cpu_count_q;
  assign max_age     = max_age_q;
`endif

endmodule

// File: tb/tb_video_mem_responder.sv
module tb_video_mem_responder;

  localparam int AW = 17;
  localparam logic [AW-1:0] CPU_RD_ADDR = 17'h00100;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          pix_stb;
  logic [AW-1:0] vid_addr;
  logic [7:0]    vid_din;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ack;
  logic [7:0]    mem_rdata;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata, cpu_rdata;
  logic          cpu_ack;
  logic          underrun;
`ifdef VIDMEM_STATS_EN
  logic          vsync;
  logic [15:0]   fetch_count, cpu_count;
  logic [3:0]    max_age;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  int   ack_delay = 2;
  logic pix_en = 1'b0;
  int   req_rises = 0;
  int   rd_rises = 0;
  int   vid_grants = 0;
  logic settle_chk = 1'b0;
  logic exp_underrun = 1'b0;
  logic [7:0] ram [0:(1<<AW)-1];

  always #5 clk_sys = ~clk_sys;

  video_mem_responder dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .pix_stb   (pix_stb),
    .vid_addr  (vid_addr),
    .vid_din   (vid_din),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
`ifdef VIDMEM_STATS_EN
    .vsync       (vsync),
    .fetch_count (fetch_count),
    .cpu_count   (cpu_count),
    .max_age     (max_age),
`endif
    .underrun  (underrun)
  );

  function automatic logic [7:0] ram_init(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'h5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel strobe: one clock in four while enabled.
  task automatic pix_gen();
    int pc;
    pc = 0;
    forever begin
      @(negedge clk_sys);
      if (!pix_en) begin
        pix_stb = 1'b0;
        pc = 0;
      end else begin
        pix_stb = (pc == 0);
        pc = (pc + 1) % 4;
      end
    end
  endtask

  // RAM model: acks ack_delay clocks after a request appears; writes update ram.
  task automatic responder();
    int   cnt;
    logic busy;
    cnt = 0;
    busy = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        busy = 1'b0;
        cnt = 0;
        mem_ack = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (!busy) begin
          busy = 1'b1;
          cnt = 0;
        end
        cnt++;
        if (cnt >= ack_delay) begin
          mem_ack = 1'b1;
          mem_rdata = ram[mem_addr];
          if (mem_we) ram[mem_addr] = mem_wdata;
          busy = 1'b0;
        end
      end else begin
        busy = 1'b0;
      end
    end
  endtask

  // Per-cycle compare: handshake rules always, displayed byte when settled.
  task automatic monitor();
    logic          p_valid;
    logic          p_req;
    logic [AW-1:0] p_addr;
    p_valid = 1'b0;
    p_req = 1'b0;
    p_addr = '0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (reset) begin
        p_valid = 1'b0;
      end else begin
        if (p_valid && p_req && !mem_ack) begin
          check("req_hold", mem_req, 1);
          check("addr_hold", mem_addr, p_addr);
        end
        if (mem_ack) check("req_drop_after_ack", mem_req, 0);
        if (p_valid && !p_req && mem_req) begin
          req_rises++;
          if (!mem_we) rd_rises++;
          if (mem_addr != CPU_RD_ADDR) vid_grants++;
        end
        if (settle_chk) begin
          check("vid_din_model", vid_din, ram[vid_addr]);
          check("underrun_model", underrun, exp_underrun);
        end
        p_valid = 1'b1;
        p_req = mem_req;
        p_addr = mem_addr;
      end
    end
  endtask

  task automatic settle(input int n);
    settle_chk = 1'b0;
    repeat (n) @(negedge clk_sys);
    settle_chk = 1'b1;
    repeat (8) @(negedge clk_sys);
    settle_chk = 1'b0;
  endtask

  task automatic wait_req(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_sys);
      #1;
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_vid(input int budget, input logic [7:0] exp, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_sys);
      #1;
      if (vid_din == exp) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                            output logic ok);
    ok = 1'b0;
    @(negedge clk_sys);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      if (cpu_ack) begin
        ok = 1'b1;
        break;
      end
    end
    cpu_req = 1'b0;
    cpu_we = 1'b0;
  endtask

  initial begin
    logic ok;
    int   base;
    int   grants;
    reset = 1'b1;
    pix_stb = 1'b0;
    vid_addr = '0;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = 8'h00;
`ifdef VIDMEM_STATS_EN
    vsync = 1'b0;
`endif
    for (int i = 0; i < (1 << AW); i++) ram[i] = ram_init(i[AW-1:0]);
    ram[17'h01234] = 8'hA5;
    ram[17'h00100] = 8'h3C;
    ram[17'h02000] = 8'h11;

    fork
      pix_gen();
      responder();
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk_sys);
    check("rst_vid_din", vid_din, 8'h00);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 8'h00);
    check("rst_cpu_rdata", cpu_rdata, 8'h00);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_underrun", underrun, 0);
    reset = 1'b0;
    pix_en = 1'b1;
    settle(24);
    check("boot_vid_din", vid_din, 8'h5A);

    // Address change, no CPU
    base = req_rises;
    @(negedge clk_sys);
    vid_addr = 17'h01234;
    wait_req(12, ok);
    check("t1_req_seen", ok, 1);
    check("t1_mem_addr", mem_addr, 17'h01234);
    check("t1_mem_we", mem_we, 0);
    wait_vid(4, 8'hA5, ok);
    check("t1_vid_latency", ok, 1);
    check("t1_vid_din", vid_din, 8'hA5);
    check("t1_underrun", underrun, 0);

    // Same address held for 16+ strobes: one request total
    settle(56);
    check("t2_single_req", req_rises - base, 1);

    // Contention: CPU read held while video moves every 8 strobes
    base = vid_grants;
    grants = -1;
    ok = 1'b0;
    @(negedge clk_sys);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = CPU_RD_ADDR;
    vid_addr = 17'h05000;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_sys);
      if (c % 32 == 31) vid_addr = vid_addr + 17'd1;
      if (cpu_ack) begin
        ok = 1'b1;
        grants = vid_grants - base;
        break;
      end
    end
    cpu_req = 1'b0;
    check("t3_cpu_ack_seen", ok, 1);
    check("t3_grants_le3", (grants >= 0) && (grants <= 3), 1);
    check("t3_cpu_rdata", cpu_rdata, 8'h3C);
    settle(24);

    // Deadline miss, then on-time fetches keep underrun sticky
    check("t4_underrun_before", underrun, 0);
    ack_delay = 24;
    @(negedge clk_sys);
    vid_addr = 17'h03000;
    exp_underrun = 1'b1;
    settle(48);
    check("t4_underrun_set", underrun, 1);
    ack_delay = 2;
    @(negedge clk_sys);
    vid_addr = 17'h03001;
    settle(24);
    check("t4_underrun_sticky", underrun, 1);

    // Snoop: CPU write to the displayed byte
    @(negedge clk_sys);
    vid_addr = 17'h02000;
    settle(24);
    check("t5_vid_before", vid_din, 8'h11);
    base = rd_rises;
    cpu_access(1'b1, 17'h02000, 8'h2F, ok);
    check("t5_cpu_ack_seen", ok, 1);
    settle(40);
    check("t5_vid_snoop", vid_din, 8'h2F);
    check("t5_no_refetch", rd_rises - base, 0);

    // Reset in the middle of a video request
    ack_delay = 40;
    @(negedge clk_sys);
    vid_addr = 17'h04000;
    wait_req(12, ok);
    check("t6_req_seen", ok, 1);
    @(negedge clk_sys);
    reset = 1'b1;
    #1;
    check("t6_rst_mem_req", mem_req, 0);
    check("t6_rst_vid_din", vid_din, 8'h00);
    check("t6_rst_underrun", underrun, 0);
    repeat (2) @(negedge clk_sys);
    exp_underrun = 1'b0;
    ack_delay = 2;
    reset = 1'b0;
    wait_req(12, ok);
    check("t6_refetch_seen", ok, 1);
    check("t6_refetch_addr", mem_addr, 17'h04000);
    settle(20);
    check("t6_vid_din", vid_din, 8'h1A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
